// File: rtl/alkqseq.sv
// ALK Q shift register with shift-in selection and an internal step sequencer.
// Optional sticky right-shift flag enabled by defining ALKQSEQ_STICKY_EN.
module alkqseq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_h,
   input  logic             start_h,
   input  logic [2:0]       mode_h,
   input  logic [1:0]       size_h,
   input  logic [1:0]       sin_sel_h,
   input  logic [CNT_W-1:0] count_h,
   input  logic [WIDTH-1:0] wbus_in_h,
   input  logic             pslc_h,
   input  logic             c32_in_h,
   input  logic             alu_sout_shr_h,
   output logic [WIDTH-1:0] q_h,
   output logic             q_sout_shl_h,
   output logic             q_sout_shr_h,
   output logic             busy_h,
   output logic             loopf_h,
   output logic             done_h,
   output logic             q_sticky_h
);

   localparam logic [2:0] M_HOLD = 3'd0;
   localparam logic [2:0] M_LOAD = 3'd1;
   localparam logic [2:0] M_SL   = 3'd2;
   localparam logic [2:0] M_SR   = 3'd3;
   localparam logic [2:0] M_ROL  = 3'd4;
   localparam logic [2:0] M_ROR  = 3'd5;
   localparam logic [2:0] M_MUL  = 3'd6;
   localparam logic [2:0] M_DIV  = 3'd7;

   localparam logic [WIDTH-1:0] MASK_B = {{(WIDTH - WIDTH/4){1'b0}}, {(WIDTH/4){1'b1}}};
   localparam logic [WIDTH-1:0] MASK_W = {{(WIDTH - WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};
   localparam logic [WIDTH-1:0] MASK_L = {WIDTH{1'b1}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] q_r, q_next;
   logic [CNT_W-1:0] rem, rem_next;
   logic [2:0]       mode_r, mode_next;
   logic [1:0]       size_r, size_next;
   logic [1:0]       sel_r, sel_next;

   logic [2:0]       cur_mode;
   logic [1:0]       cur_size;
   logic [1:0]       cur_sel;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] stepped;
   logic             sel_bit;
   logic             sin;
   logic             shift_left;
   logic             right_step;
   logic             step_en;

   function automatic logic pick_msb(input logic [WIDTH-1:0] v, input logic [1:0] size);
      logic b;
      case (size)
         2'd0:    b = v[WIDTH/4-1];
         2'd1:    b = v[WIDTH/2-1];
         default: b = v[WIDTH-1];
      endcase
      return b;
   endfunction

   // Step datapath: the first step uses live controls, later steps use the latched copy.
   always_comb begin
      cur_mode   = (state == IDLE) ? mode_h    : mode_r;
      cur_size   = (state == IDLE) ? size_h    : size_r;
      cur_sel    = (state == IDLE) ? sin_sel_h : sel_r;
      mask       = MASK_L;
      sel_bit    = 1'b0;
      sin        = 1'b0;
      shift_left = 1'b0;
      right_step = 1'b0;
      case (cur_size)
         2'd0:    mask = MASK_B;
         2'd1:    mask = MASK_W;
         default: mask = MASK_L;
      endcase
      case (cur_sel)
         2'd0:    sel_bit = 1'b0;
         2'd1:    sel_bit = 1'b1;
         2'd2:    sel_bit = pslc_h;
         default: sel_bit = pick_msb(wbus_in_h, cur_size);
      endcase
      case (cur_mode)
         M_SL:    begin shift_left = 1'b1; sin = sel_bit; end
         M_SR:    begin right_step = 1'b1; sin = sel_bit; end
         M_ROL:   begin shift_left = 1'b1; sin = pick_msb(q_r, cur_size); end
         M_ROR:   begin right_step = 1'b1; sin = q_r[0]; end
         M_MUL:   begin right_step = 1'b1; sin = alu_sout_shr_h; end
         M_DIV:   begin shift_left = 1'b1; sin = c32_in_h; end
         default: begin shift_left = 1'b0; sin = 1'b0; end
      endcase
      // mask ^ (mask >> 1) isolates bit EW-1, where the right-shift input lands
      if (shift_left)
         shifted = (q_r << 1) | {{(WIDTH-1){1'b0}}, sin};
      else
         shifted = ((q_r & mask) >> 1) | (sin ? (mask ^ (mask >> 1)) : '0);
      stepped = (shifted & mask) | (q_r & ~mask);
      step_en = ((state == IDLE) && start_h && (mode_h != M_HOLD) && (mode_h != M_LOAD))
                || (state == RUN);
   end

   // Sequencer next-state and register updates.
   always_comb begin
      state_next = state;
      q_next     = q_r;
      rem_next   = rem;
      mode_next  = mode_r;
      size_next  = size_r;
      sel_next   = sel_r;
      case (state)
         IDLE: begin
            if (start_h && mode_h == M_LOAD) begin
               q_next     = wbus_in_h;
               state_next = DONE;
            end else if (step_en) begin
               q_next     = stepped;
               rem_next   = count_h;
               mode_next  = mode_h;
               size_next  = size_h;
               sel_next   = sin_sel_h;
               state_next = (count_h == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            q_next   = stepped;
            rem_next = rem - CNT_W'(1);
            if (rem <= CNT_W'(1))
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_h) begin
         state  <= IDLE;
         q_r    <= '0;
         rem    <= '0;
         mode_r <= M_HOLD;
         size_r <= 2'd0;
         sel_r  <= 2'd0;
      end else begin
         state  <= state_next;
         q_r    <= q_next;
         rem    <= rem_next;
         mode_r <= mode_next;
         size_r <= size_next;
         sel_r  <= sel_next;
      end
   end

`ifdef ALKQSEQ_STICKY_EN
   logic sticky;
   logic start_accept;

   // Any accepted start clears the flag; the first step may immediately set it.
   assign start_accept = (state == IDLE) && start_h && (mode_h != M_HOLD);

   always_ff @(posedge clk) begin
      if (reset_h)
         sticky <= 1'b0;
      else if (start_accept)
         sticky <= step_en & right_step & q_r[0];
      else if (step_en && right_step)
         sticky <= sticky | q_r[0];
   end

   assign q_sticky_h = sticky;
`else
   assign q_sticky_h = 1'b0;
`endif

   assign q_h          = q_r;
   assign q_sout_shl_h = pick_msb(q_r, size_h);
   assign q_sout_shr_h = q_r[0];
   assign busy_h       = (state == RUN);
   assign loopf_h      = (state == RUN) && (rem > CNT_W'(1));
   assign done_h       = (state == DONE);

endmodule

// File: tb/tb_alkqseq.sv
// Directed scoreboard bench for alkqseq: expected Q values are queued at stimulus
// time and popped when done_h appears.
module tb_alkqseq;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             reset_h;
   logic             start_h;
   logic [2:0]       mode_h;
   logic [1:0]       size_h;
   logic [1:0]       sin_sel_h;
   logic [CNT_W-1:0] count_h;
   logic [WIDTH-1:0] wbus_in_h;
   logic             pslc_h;
   logic             c32_in_h;
   logic             alu_sout_shr_h;
   logic [WIDTH-1:0] q_h;
   logic             q_sout_shl_h;
   logic             q_sout_shr_h;
   logic             busy_h;
   logic             loopf_h;
   logic             done_h;
   logic             q_sticky_h;

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] exp_q[$];

   alkqseq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_h(reset_h), .start_h(start_h), .mode_h(mode_h),
      .size_h(size_h), .sin_sel_h(sin_sel_h), .count_h(count_h),
      .wbus_in_h(wbus_in_h), .pslc_h(pslc_h), .c32_in_h(c32_in_h),
      .alu_sout_shr_h(alu_sout_shr_h), .q_h(q_h), .q_sout_shl_h(q_sout_shl_h),
      .q_sout_shr_h(q_sout_shr_h), .busy_h(busy_h), .loopf_h(loopf_h),
      .done_h(done_h), .q_sticky_h(q_sticky_h)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Pulse start_h for one edge with the given controls; returns just after the start edge.
   task automatic applyStimulus(input logic [2:0] mode, input logic [1:0] size,
                                input logic [1:0] sel, input int count, input logic [31:0] wbus);
      mode_h    = mode;
      size_h    = size;
      sin_sel_h = sel;
      count_h   = CNT_W'(count);
      wbus_in_h = wbus;
      start_h   = 1'b1;
      tick();
      start_h   = 1'b0;
      mode_h    = 3'd0;
   endtask

   // Wait (bounded) for done_h, then pop the scoreboard and compare Q.
   task automatic waitDone(input string tag, input int budget, output int edges);
      logic [31:0] expv;
      edges = 1;
      while (!done_h && edges < budget) begin
         tick();
         edges++;
      end
      checkOutput({tag, " done"}, {31'd0, done_h}, 32'd1);
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      checkOutput({tag, " q"}, q_h, expv);
   endtask

   task automatic loadQ(input string tag, input logic [31:0] v);
      int e;
      exp_q.push_back(v);
      applyStimulus(3'd1, 2'd2, 2'd0, 7, v);
      waitDone(tag, 4, e);
      checkOutput({tag, " edges"}, e, 1);
      tick();
   endtask

   initial begin
      int e;
      int loopf_cnt;
      int done_cnt;
      reset_h = 1'b1; start_h = 1'b0; mode_h = 3'd0; size_h = 2'd2; sin_sel_h = 2'd0;
      count_h = '0; wbus_in_h = '0; pslc_h = 1'b0; c32_in_h = 1'b0; alu_sout_shr_h = 1'b0;
      tick(); tick();
      reset_h = 1'b0;
      checkOutput("reset q", q_h, 32'h0);
      checkOutput("reset busy", {31'd0, busy_h}, 32'd0);
      checkOutput("reset loopf", {31'd0, loopf_h}, 32'd0);
      checkOutput("reset done", {31'd0, done_h}, 32'd0);
      checkOutput("reset sticky", {31'd0, q_sticky_h}, 32'd0);

      // Reset during a 10-step SL: asserted for the 4th edge.
      loadQ("t1 load", 32'h1234_5678);
      applyStimulus(3'd2, 2'd2, 2'd1, 9, 32'h0);
      tick(); tick();
      reset_h = 1'b1;
      tick();
      reset_h = 1'b0;
      checkOutput("t1 q", q_h, 32'h0);
      checkOutput("t1 busy", {31'd0, busy_h}, 32'd0);
      checkOutput("t1 done", {31'd0, done_h}, 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done_h) done_cnt++;
      end
      checkOutput("t1 late done", done_cnt, 0);

      // SR long with constant-1 shift-in, 4 steps.
      loadQ("t2 load", 32'h8000_0001);
      exp_q.push_back(32'hF800_0000);
      applyStimulus(3'd3, 2'd2, 2'd1, 3, 32'h0);
      waitDone("t2", 10, e);
      checkOutput("t2 edges", e, 4);
      tick();

      // ROL byte, single step: no RUN state.
      loadQ("t3 load", 32'h1234_5681);
      exp_q.push_back(32'h1234_5603);
      applyStimulus(3'd4, 2'd0, 2'd0, 0, 32'h0);
      checkOutput("t3 busy", {31'd0, busy_h}, 32'd0);
      waitDone("t3", 3, e);
      checkOutput("t3 edges", e, 1);
      tick();

      // MUL long 32 steps, shift-in 1; count loopf cycles.
      loadQ("t4 load", 32'h0000_0000);
      alu_sout_shr_h = 1'b1;
      exp_q.push_back(32'hFFFF_FFFF);
      applyStimulus(3'd6, 2'd2, 2'd0, 31, 32'h0);
      e = 1; loopf_cnt = 0;
      while (!done_h && e < 60) begin
         if (loopf_h) loopf_cnt++;
         tick();
         e++;
      end
      checkOutput("t4 loopf cycles", loopf_cnt, 30);
      checkOutput("t4 edges", e, 32);
      checkOutput("t4 q", q_h, exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx);
      alu_sout_shr_h = 1'b0;
      tick();

      // SL word 6 steps with stray starts in RUN and in DONE.
      loadQ("t5 load", 32'h0F0F_0F0F);
      exp_q.push_back(32'h0F0F_C3C0);
      applyStimulus(3'd2, 2'd1, 2'd0, 5, 32'h0);
      tick();
      mode_h = 3'd1; wbus_in_h = 32'hDEAD_BEEF; start_h = 1'b1;
      tick();
      start_h = 1'b0; mode_h = 3'd0;
      e = 3;
      while (!done_h && e < 20) begin
         tick();
         e++;
      end
      checkOutput("t5 edges", e, 6);
      checkOutput("t5 q", q_h, exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx);
      mode_h = 3'd1; start_h = 1'b1;
      tick();
      start_h = 1'b0; mode_h = 3'd0;
      checkOutput("t5 done-start busy", {31'd0, busy_h}, 32'd0);
      checkOutput("t5 done-start q", q_h, 32'h0F0F_C3C0);
      tick();
      checkOutput("t5 no extra done", {31'd0, done_h}, 32'd0);

      // Live shift sources: PSL.C, WBUS MSB, carry; plus ROR long.
      loadQ("t7 load", 32'h0000_00F0);
      pslc_h = 1'b1;
      exp_q.push_back(32'h0000_00FC);
      applyStimulus(3'd3, 2'd0, 2'd2, 1, 32'h0);
      waitDone("t7 pslc", 6, e);
      pslc_h = 1'b0;
      tick();
      loadQ("t8 load", 32'h0001_0000);
      exp_q.push_back(32'h0001_C000);
      applyStimulus(3'd3, 2'd1, 2'd3, 1, 32'h0000_8000);
      waitDone("t8 wbus", 6, e);
      tick();
      size_h = 2'd1; #1;
      checkOutput("t8 shl word", {31'd0, q_sout_shl_h}, 32'd1);
      size_h = 2'd0; #1;
      checkOutput("t8 shl byte", {31'd0, q_sout_shl_h}, 32'd0);
      loadQ("t9 load", 32'hFFFF_0000);
      c32_in_h = 1'b1;
      exp_q.push_back(32'hFFFF_000F);
      applyStimulus(3'd7, 2'd1, 2'd0, 3, 32'h0);
      waitDone("t9 div", 8, e);
      c32_in_h = 1'b0;
      tick();
      loadQ("t10 load", 32'h0000_000F);
      exp_q.push_back(32'hF000_0000);
      applyStimulus(3'd5, 2'd2, 2'd0, 3, 32'h0);
      waitDone("t10 ror", 8, e);
      tick();

`ifdef ALKQSEQ_STICKY_EN
      loadQ("t6 load a", 32'h0000_0004);
      exp_q.push_back(32'h0000_0001);
      applyStimulus(3'd3, 2'd2, 2'd0, 1, 32'h0);
      waitDone("t6 a", 6, e);
      checkOutput("t6 sticky 2 steps", {31'd0, q_sticky_h}, 32'd0);
      tick();
      loadQ("t6 load b", 32'h0000_0004);
      exp_q.push_back(32'h0000_0000);
      applyStimulus(3'd3, 2'd2, 2'd0, 2, 32'h0);
      waitDone("t6 b", 6, e);
      checkOutput("t6 sticky 3 steps", {31'd0, q_sticky_h}, 32'd1);
      tick(); tick();
      checkOutput("t6 sticky held", {31'd0, q_sticky_h}, 32'd1);
      loadQ("t6 load c", 32'h0000_0001);
      checkOutput("t6 sticky cleared", {31'd0, q_sticky_h}, 32'd0);
`else
      checkOutput("t6 sticky tied", {31'd0, q_sticky_h}, 32'd0);
`endif

      checkOutput("scoreboard empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
